// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default geometry, PHT controller states
// and the 2-bit saturating counter update.
package bp_pkg;

    localparam int IDX_W_DEF  = 12;
    localparam int GHR_W_DEF  = 12;
    localparam int QDEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } pht_state_e;

    function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small in-order FIFO of resolved-branch updates {idx, taken}; the head entry
// stays stable until popped so a read-modify-write can use it for several cycles.
module pht_upd_fifo #(
    parameter int IDX_W  = 12,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_taken,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] head_idx,
    output logic             head_taken
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [IDX_W:0]   mem_q [QDEPTH];
    logic [IDX_W:0]   mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(QDEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign full       = (count_q == CNT_W'(QDEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_idx   = mem_q[rd_ptr_q][IDX_W-1:0];
    assign head_taken = mem_q[rd_ptr_q][IDX_W];
    assign push_ok_s  = push & ~full;
    assign pop_ok_s   = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = {push_taken, push_idx};
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pht_access_ctrl.sv
// Arbitrates the single-port gshare PHT between fetch lookups and buffered
// execute-stage counter updates; owns the GHR and the post-reset table sweep.
module pht_access_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int GHR_W  = GHR_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             lk_ready,
    output logic             lk_resp_valid,
    output logic             lk_taken,
    output logic [IDX_W-1:0] lk_idx,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_taken,
    output logic             up_ready,
    input  logic             mispredict,
    input  logic [GHR_W-1:0] mp_ghr,
    output logic             pht_en,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_addr,
    output logic [1:0]       pht_wdata,
    input  logic [1:0]       pht_rdata,
    output logic [GHR_W-1:0] ghr
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    pht_state_e       state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0] lk_idx_q, lk_idx_d;
    logic [1:0]       new_cnt_q, new_cnt_d;

    logic [IDX_W-1:0] lk_hash_s;
    logic             lk_taken_s;
    logic             upd_go_s;
    logic             pht_en_s, pht_we_s;
    logic [IDX_W-1:0] pht_addr_s;
    logic [1:0]       pht_wdata_s;
    logic             lk_ready_s;
    logic             fifo_push_s, fifo_pop_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_taken_s;
    logic             unused_pc_s;

    assign lk_hash_s   = lk_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign unused_pc_s = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};
    // The read issued on the accept cycle returns in the response cycle.
    assign lk_taken_s  = resp_valid_q & pht_rdata[1];
    assign upd_go_s    = fifo_full_s | (~fifo_empty_s & ~lk_valid);
    assign fifo_push_s = up_valid & up_ready;

    pht_upd_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push_s),
        .push_idx   (up_idx),
        .push_taken (up_taken),
        .pop        (fifo_pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s),
        .head_idx   (head_idx_s),
        .head_taken (head_taken_s)
    );

    // Port sequencing FSM: sweep, then lookup vs. update arbitration and RMW.
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        resp_valid_d = 1'b0;
        lk_idx_d     = lk_idx_q;
        new_cnt_d    = new_cnt_q;
        pht_en_s     = 1'b0;
        pht_we_s     = 1'b0;
        pht_addr_s   = '0;
        pht_wdata_s  = 2'b00;
        lk_ready_s   = 1'b0;
        fifo_pop_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                pht_en_s    = 1'b1;
                pht_we_s    = 1'b1;
                pht_addr_s  = init_ptr_q;
                pht_wdata_s = 2'b11;
                if (init_ptr_q == '1) begin
                    init_ptr_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_ptr_d = init_ptr_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (upd_go_s) begin
                    pht_en_s   = 1'b1;
                    pht_addr_s = head_idx_s;
                    state_d    = ST_UPD_RD;
                end else if (lk_valid) begin
                    lk_ready_s   = 1'b1;
                    pht_en_s     = 1'b1;
                    pht_addr_s   = lk_hash_s;
                    lk_idx_d     = lk_hash_s;
                    // A redirect kills the response of a lookup accepted alongside it.
                    resp_valid_d = ~mispredict;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPD_RD: begin
                new_cnt_d = sat2(pht_rdata, head_taken_s);
                state_d   = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                pht_en_s    = 1'b1;
                pht_we_s    = 1'b1;
                pht_addr_s  = head_idx_s;
                pht_wdata_s = new_cnt_q;
                fifo_pop_s  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
            end
        endcase
    end

    // Speculative history: restore on redirect, otherwise shift in predictions.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = mp_ghr;
        end else if (resp_valid_q) begin
            ghr_d = {ghr_q[GHR_W-2:0], lk_taken_s};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Port outputs are held quiet while reset is asserted so no write lands on the reset edge.
    always_comb begin
        if (rst_n) begin
            pht_en    = pht_en_s;
            pht_we    = pht_we_s;
            pht_addr  = pht_addr_s;
            pht_wdata = pht_wdata_s;
            lk_ready  = lk_ready_s;
            up_ready  = (state_q != ST_INIT) && (fifo_count_s != CNT_W'(QDEPTH));
        end else begin
            pht_en    = 1'b0;
            pht_we    = 1'b0;
            pht_addr  = '0;
            pht_wdata = 2'b00;
            lk_ready  = 1'b0;
            up_ready  = 1'b0;
        end
    end

    // Controller state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            ghr_q        <= '0;
            resp_valid_q <= 1'b0;
            lk_idx_q     <= '0;
            new_cnt_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ghr_q        <= ghr_d;
            resp_valid_q <= resp_valid_d;
            lk_idx_q     <= lk_idx_d;
            new_cnt_q    <= new_cnt_d;
        end
    end

    assign lk_resp_valid = resp_valid_q;
    assign lk_taken      = lk_taken_s;
    assign lk_idx        = lk_idx_q;
    assign ghr           = ghr_q;

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Directed bench for pht_access_ctrl with a behavioural single-port PHT SRAM.
module tb_pht_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_ready;
    logic        lk_resp_valid;
    logic        lk_taken;
    logic [11:0] lk_idx;
    logic        up_valid;
    logic [11:0] up_idx;
    logic        up_taken;
    logic        up_ready;
    logic        mispredict;
    logic [11:0] mp_ghr;
    logic        pht_en;
    logic        pht_we;
    logic [11:0] pht_addr;
    logic [1:0]  pht_wdata;
    logic [1:0]  pht_rdata;
    logic [11:0] ghr;

    logic [1:0]  pht_mem [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pht_access_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_valid      (lk_valid),
        .lk_pc         (lk_pc),
        .lk_ready      (lk_ready),
        .lk_resp_valid (lk_resp_valid),
        .lk_taken      (lk_taken),
        .lk_idx        (lk_idx),
        .up_valid      (up_valid),
        .up_idx        (up_idx),
        .up_taken      (up_taken),
        .up_ready      (up_ready),
        .mispredict    (mispredict),
        .mp_ghr        (mp_ghr),
        .pht_en        (pht_en),
        .pht_we        (pht_we),
        .pht_addr      (pht_addr),
        .pht_wdata     (pht_wdata),
        .pht_rdata     (pht_rdata),
        .ghr           (ghr)
    );

    // Single-port SRAM: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we) pht_mem[pht_addr] <= pht_wdata;
            else        pht_rdata <= pht_mem[pht_addr];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; lk_valid = 1'b0; lk_pc = 32'h0; up_valid = 1'b0;
        up_idx = 12'h0; up_taken = 1'b0; mispredict = 1'b0; mp_ghr = 12'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (pht_we !== 1'b0) begin errors++; $display("FAIL reset_pht_we got %0b exp 0", pht_we); end
        checks++; if (pht_en !== 1'b0) begin errors++; $display("FAIL reset_pht_en got %0b exp 0", pht_en); end
        checks++; if (pht_addr !== 12'h000) begin errors++; $display("FAIL reset_pht_addr got %h exp 000", pht_addr); end
        checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b exp 0", lk_resp_valid); end
        checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL reset_lk_taken got %0b exp 0", lk_taken); end
        checks++; if (lk_idx !== 12'h000) begin errors++; $display("FAIL reset_lk_idx got %h exp 000", lk_idx); end
        checks++; if (ghr !== 12'h000) begin errors++; $display("FAIL reset_ghr got %h exp 000", ghr); end
        checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL reset_up_ready got %0b exp 0", up_ready); end
    endtask

    task automatic test_init_sweep();
        int bad_we = 0, bad_addr = 0, bad_data = 0, bad_rdy = 0, bad_mem = 0;
        @(negedge clk);
        rst_n = 1'b1; lk_valid = 1'b1; lk_pc = 32'h10; up_valid = 1'b1; up_idx = 12'h004;
        #1;
        for (int c = 0; c < 4096; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (pht_we !== 1'b1 || pht_en !== 1'b1) bad_we++;
            if (pht_addr !== 12'(c)) bad_addr++;
            if (pht_wdata !== 2'b11) bad_data++;
            if (lk_ready !== 1'b0 || up_ready !== 1'b0) bad_rdy++;
        end
        lk_valid = 1'b0; up_valid = 1'b0;
        checks++; if (bad_we != 0) begin errors++; $display("FAIL init_we_cycles bad %0d exp 0", bad_we); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL init_addr_seq bad %0d exp 0", bad_addr); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL init_wdata bad %0d exp 0", bad_data); end
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL init_ready_low bad %0d exp 0", bad_rdy); end
        @(negedge clk); #1;
        checks++; if (pht_en !== 1'b0) begin errors++; $display("FAIL init_done_idle pht_en got %0b exp 0", pht_en); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL init_done_up_ready got %0b exp 1", up_ready); end
        for (int a = 0; a < 4096; a++) if (pht_mem[a] !== 2'b11) bad_mem++;
        checks++; if (bad_mem != 0) begin errors++; $display("FAIL init_table_value bad %0d exp 0", bad_mem); end
    endtask

    task automatic test_lookup();
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = 32'h0000_0010;
        #1;
        checks++; if (lk_ready !== 1'b1) begin errors++; $display("FAIL lookup_ready got %0b exp 1", lk_ready); end
        checks++; if (pht_en !== 1'b1 || pht_we !== 1'b0 || pht_addr !== 12'h004)
            begin errors++; $display("FAIL lookup_read en %0b we %0b addr %h exp 1 0 004", pht_en, pht_we, pht_addr); end
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        checks++; if (lk_resp_valid !== 1'b1) begin errors++; $display("FAIL lookup_resp_valid got %0b exp 1", lk_resp_valid); end
        checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL lookup_taken got %0b exp 1", lk_taken); end
        checks++; if (lk_idx !== 12'h004) begin errors++; $display("FAIL lookup_idx got %h exp 004", lk_idx); end
        @(negedge clk); #1;
        checks++; if (ghr !== 12'h001) begin errors++; $display("FAIL lookup_ghr got %h exp 001", ghr); end
        checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("FAIL lookup_single_resp got %0b exp 0", lk_resp_valid); end
    endtask

    task automatic test_counter_updates();
        logic [1:0]  exp_w [4];
        logic [1:0]  got_w [$];
        logic [11:0] got_a [$];
        int bad_rdy = 0;
        exp_w[0] = 2'b10; exp_w[1] = 2'b01; exp_w[2] = 2'b00; exp_w[3] = 2'b00;
        for (int n = 0; n < 40 && got_w.size() < 4; n++) begin
            @(negedge clk);
            up_valid = (n < 4); up_idx = 12'h004; up_taken = 1'b0;
            #1;
            if (n < 4 && up_ready !== 1'b1) bad_rdy++;
            if (pht_we === 1'b1) begin got_w.push_back(pht_wdata); got_a.push_back(pht_addr); end
        end
        up_valid = 1'b0;
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL upd_push_ready bad %0d exp 0", bad_rdy); end
        checks++; if (got_w.size() != 4) begin errors++; $display("FAIL upd_write_count got %0d exp 4", got_w.size()); end
        for (int k = 0; k < got_w.size() && k < 4; k++) begin
            checks++;
            if (got_w[k] !== exp_w[k] || got_a[k] !== 12'h004)
                begin errors++; $display("FAIL upd_write%0d addr %h data %0d exp 004 %0d", k, got_a[k], got_w[k], exp_w[k]); end
        end
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = 32'h0000_0014;
        #1;
        checks++; if (lk_ready !== 1'b1 || pht_addr !== 12'h004)
            begin errors++; $display("FAIL upd_lookup_addr ready %0b addr %h exp 1 004", lk_ready, pht_addr); end
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        checks++; if (lk_resp_valid !== 1'b1 || lk_taken !== 1'b0)
            begin errors++; $display("FAIL upd_lookup_taken valid %0b taken %0b exp 1 0", lk_resp_valid, lk_taken); end
        checks++; if (lk_idx !== 12'h004) begin errors++; $display("FAIL upd_lookup_idx got %h exp 004", lk_idx); end
        @(negedge clk); #1;
        checks++; if (ghr !== 12'h002) begin errors++; $display("FAIL upd_lookup_ghr got %h exp 002", ghr); end
    endtask

    task automatic test_fifo_full();
        logic [1:0]  got_w [$];
        logic [11:0] got_a [$];
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lk_valid = 1'b1; lk_pc = 32'h0;
            up_valid = 1'b1; up_idx = 12'h100 + 12'(i); up_taken = (i == 0);
            #1;
            if (up_ready !== 1'b1 || lk_ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_fill_lookup_wins bad %0d exp 0", bad); end
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL full_up_ready got %0b exp 0", up_ready); end
        checks++; if (lk_ready !== 1'b0 || pht_en !== 1'b1 || pht_we !== 1'b0 || pht_addr !== 12'h100)
            begin errors++; $display("FAIL full_upd_rd rdy %0b en %0b we %0b addr %h exp 0 1 0 100", lk_ready, pht_en, pht_we, pht_addr); end
        @(negedge clk); #1;
        checks++; if (lk_ready !== 1'b0 || pht_en !== 1'b0)
            begin errors++; $display("FAIL full_upd_data rdy %0b en %0b exp 0 0", lk_ready, pht_en); end
        @(negedge clk); #1;
        checks++; if (lk_ready !== 1'b0 || pht_we !== 1'b1 || pht_addr !== 12'h100 || pht_wdata !== 2'b11)
            begin errors++; $display("FAIL full_upd_wr rdy %0b we %0b addr %h data %0d exp 0 1 100 3", lk_ready, pht_we, pht_addr, pht_wdata); end
        @(negedge clk); #1;
        checks++; if (lk_ready !== 1'b1 || up_ready !== 1'b1)
            begin errors++; $display("FAIL full_lookup_resume lk %0b up %0b exp 1 1", lk_ready, up_ready); end
        for (int n = 0; n < 30 && got_w.size() < 3; n++) begin
            @(negedge clk);
            lk_valid = 1'b0;
            #1;
            if (pht_we === 1'b1) begin got_w.push_back(pht_wdata); got_a.push_back(pht_addr); end
        end
        checks++; if (got_w.size() != 3) begin errors++; $display("FAIL full_drain_count got %0d exp 3", got_w.size()); end
        for (int k = 0; k < got_w.size() && k < 3; k++) begin
            checks++;
            if (got_a[k] !== 12'h101 + 12'(k) || got_w[k] !== 2'b10)
                begin errors++; $display("FAIL full_drain%0d addr %h data %0d exp %h 2", k, got_a[k], got_w[k], 12'h101 + 12'(k)); end
        end
    endtask

    task automatic test_mispredict();
        repeat (2) @(negedge clk);
        lk_valid = 1'b1; lk_pc = 32'h10; mispredict = 1'b1; mp_ghr = 12'hABC;
        #1;
        checks++; if (lk_ready !== 1'b1) begin errors++; $display("FAIL mp_accept got %0b exp 1", lk_ready); end
        @(negedge clk);
        lk_valid = 1'b0; mispredict = 1'b0;
        #1;
        checks++; if (ghr !== 12'hABC) begin errors++; $display("FAIL mp_ghr_restore got %h exp abc", ghr); end
        checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("FAIL mp_resp_suppressed got %0b exp 0", lk_resp_valid); end
        @(negedge clk); #1;
        checks++; if (ghr !== 12'hABC) begin errors++; $display("FAIL mp_ghr_hold got %h exp abc", ghr); end
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = 32'h10;
        @(negedge clk);
        lk_valid = 1'b0; mispredict = 1'b1; mp_ghr = 12'h123;
        #1;
        checks++; if (lk_resp_valid !== 1'b1) begin errors++; $display("FAIL mp_shift_resp got %0b exp 1", lk_resp_valid); end
        @(negedge clk);
        mispredict = 1'b0;
        #1;
        checks++; if (ghr !== 12'h123) begin errors++; $display("FAIL mp_wins_shift got %h exp 123", ghr); end
    endtask

    task automatic test_reset_mid_wr();
        bit found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            up_valid = (n < 2); up_idx = (n == 0) ? 12'h101 : 12'h102; up_taken = 1'b1;
            #1;
            if (pht_we === 1'b1) found = 1'b1;
        end
        up_valid = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL rst_wr_reached got 0 exp 1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (pht_we !== 1'b0 || pht_en !== 1'b0)
            begin errors++; $display("FAIL rst_wr_blocked we %0b en %0b exp 0 0", pht_we, pht_en); end
        @(posedge clk); #1;
        checks++; if (pht_mem[12'h101] !== 2'b10) begin errors++; $display("FAIL rst_no_write mem %0d exp 2", pht_mem[12'h101]); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (pht_we !== 1'b1 || pht_addr !== 12'h000)
            begin errors++; $display("FAIL rst_init_restart we %0b addr %h exp 1 000", pht_we, pht_addr); end
        repeat (4096) @(negedge clk);
        #1;
        checks++; if (pht_en !== 1'b0 || up_ready !== 1'b1)
            begin errors++; $display("FAIL rst_fifo_empty en %0b up_ready %0b exp 0 1", pht_en, up_ready); end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_lookup();
        test_counter_updates();
        test_fifo_full();
        test_mispredict();
        test_reset_mid_wr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
